// File: rtl/axi_mst_wr_gen.sv
// AXI write-traffic master: turns burst commands into AW/W traffic and checks
// B responses in order against the IDs it issued. It also bounds how many bursts are outstanding.
module axi_mst_wr_gen #(
   parameter int AXI_ADDR_W      = 32,
   parameter int AXI_ID_W        = 4,
   parameter int AXI_DATA_W      = 32,
   parameter int MST_OSTDREQ_NUM = 4
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [AXI_ADDR_W-1:0]                cmd_addr,
   input  logic [3:0]                           cmd_len,
   input  logic [AXI_ID_W-1:0]                  cmd_id,
   output logic                                 out_awvalid,
   input  logic                                 in_awready,
   output logic [AXI_ADDR_W-1:0]                out_awaddr,
   output logic [3:0]                           out_awlen,
   output logic [AXI_ID_W-1:0]                  out_awid,
   output logic [2:0]                           out_awsize,
   output logic [1:0]                           out_awburst,
   output logic                                 out_wvalid,
   input  logic                                 in_wready,
   output logic [AXI_DATA_W-1:0]                out_wdata,
   output logic [AXI_DATA_W/8-1:0]              out_wstrb,
   output logic [AXI_ID_W-1:0]                  out_wid,
   output logic                                 out_wlast,
   input  logic                                 in_bvalid,
   output logic                                 out_bready,
   input  logic [AXI_ID_W-1:0]                  in_bid,
   input  logic [1:0]                           in_bresp,
   output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0] ostd_cnt,
   output logic [7:0]                           err_cnt
);

   localparam int BYTES = AXI_DATA_W / 8;
   localparam int CW    = $clog2(MST_OSTDREQ_NUM + 1);
   localparam int PW    = $clog2(MST_OSTDREQ_NUM);
   localparam logic [CW-1:0] OSTD_MAX = CW'(MST_OSTDREQ_NUM);

   typedef enum logic [1:0] {IDLE, AW, W} state_e;

   state_e                  state_q, state_d;
   logic [AXI_ADDR_W-1:0]   addr_q;
   logic [3:0]              len_q;
   logic [AXI_ID_W-1:0]     id_q;
   logic [3:0]              beat_q, beat_d;
   logic                    bready_q;
   logic [CW-1:0]           ostd_q, ostd_d;
   logic [7:0]              err_q, err_d;
   logic [PW-1:0]           wptr_q, rptr_q;
   logic [AXI_ID_W-1:0]     fifo_q [MST_OSTDREQ_NUM];

   logic cmd_hs, aw_hs, w_hs, b_hs, pop, b_err;
   logic [AXI_ADDR_W-1:0] wsum;

   assign cmd_ready = (state_q == IDLE) && (ostd_q < OSTD_MAX) && bready_q;
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign aw_hs     = out_awvalid && in_awready;
   assign w_hs      = out_wvalid && in_wready;
   assign b_hs      = in_bvalid && bready_q;
   // The outstanding count doubles as FIFO occupancy, so zero means empty.
   assign pop       = b_hs && (ostd_q != '0);
   assign b_err     = (in_bresp != 2'b00) || (ostd_q == '0) || (in_bid != fifo_q[rptr_q]);

   assign out_awvalid = (state_q == AW);
   assign out_awaddr  = addr_q;
   assign out_awlen   = len_q;
   assign out_awid    = id_q;
   assign out_awsize  = 3'($clog2(BYTES));
   assign out_awburst = 2'b01;
   assign out_wvalid  = (state_q == W);
   assign wsum        = addr_q + AXI_ADDR_W'(beat_q) * AXI_ADDR_W'(BYTES);
   assign out_wdata   = AXI_DATA_W'(wsum);
   assign out_wstrb   = '1;
   assign out_wid     = id_q;
   assign out_wlast   = (state_q == W) && (beat_q == len_q);
   assign out_bready  = bready_q;
   assign ostd_cnt    = ostd_q;
   assign err_cnt     = err_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: if (cmd_hs) state_d = AW;
         AW: if (aw_hs) begin
            state_d = W;
            beat_d  = '0;
         end
         W: if (w_hs) begin
            beat_d = beat_q + 4'd1;
            if (out_wlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ostd_d = ostd_q;
      if (cmd_hs && !pop)      ostd_d = ostd_q + CW'(1);
      else if (!cmd_hs && pop) ostd_d = ostd_q - CW'(1);
      err_d = err_q;
      if (b_hs && b_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         beat_q   <= '0;
         bready_q <= 1'b0;
         ostd_q   <= '0;
         err_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
      end else begin
         bready_q <= 1'b1;
         beat_q   <= beat_d;
         ostd_q   <= ostd_d;
         err_q    <= err_d;
         if (cmd_hs) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            id_q   <= cmd_id;
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge aclk) begin
      if (cmd_hs) fifo_q[wptr_q] <= cmd_id;
   end

endmodule

// File: tb/tb_axi_mst_wr_gen.sv
// Directed bench for axi_mst_wr_gen: single burst, backpressure, outstanding limit,
// simultaneous cmd/B, response error checks, reset mid-burst.
module tb_axi_mst_wr_gen;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic [3:0]  cmd_id = '0;
   logic        out_awvalid, in_awready = 1'b1;
   logic [31:0] out_awaddr;
   logic [3:0]  out_awlen, out_awid;
   logic [2:0]  out_awsize;
   logic [1:0]  out_awburst;
   logic        out_wvalid, in_wready = 1'b1;
   logic [31:0] out_wdata;
   logic [3:0]  out_wstrb, out_wid;
   logic        out_wlast;
   logic        in_bvalid = 1'b0, out_bready;
   logic [3:0]  in_bid = '0;
   logic [1:0]  in_bresp = '0;
   logic [2:0]  ostd_cnt;
   logic [7:0]  err_cnt;

   int errs = 0;
   int checks = 0;

   always #5 aclk = ~aclk;

   axi_mst_wr_gen dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_id(cmd_id),
      .out_awvalid(out_awvalid), .in_awready(in_awready), .out_awaddr(out_awaddr),
      .out_awlen(out_awlen), .out_awid(out_awid), .out_awsize(out_awsize),
      .out_awburst(out_awburst),
      .out_wvalid(out_wvalid), .in_wready(in_wready), .out_wdata(out_wdata),
      .out_wstrb(out_wstrb), .out_wid(out_wid), .out_wlast(out_wlast),
      .in_bvalid(in_bvalid), .out_bready(out_bready), .in_bid(in_bid),
      .in_bresp(in_bresp), .ostd_cnt(ostd_cnt), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the command handshake.
   task automatic send_cmd(input logic [31:0] a, input logic [3:0] l, input logic [3:0] id);
      int n = 0;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = id;
      while (!cmd_ready && n < 50) begin
         @(negedge aclk); n++;
      end
      chk("cmd_ready_timeout", 64'(n < 50), 1);
      @(negedge aclk);
      cmd_valid = 1'b0;
   endtask

   // Drives AW/W to completion, checking payload every cycle; returns cycles used.
   task automatic xfer(input logic [31:0] a, input logic [3:0] l, input logic [3:0] id,
                       input bit rnd, output int cyc);
      int beats = 0, lasts = 0;
      bit aw_done = 0;
      cyc = 0;
      while (beats <= int'(l) && cyc < 400) begin
         in_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (aw_done) chk("wvalid_cont", out_wvalid, 1);
         if (out_awvalid) begin
            chk("awaddr", out_awaddr, a);
            chk("awlen", out_awlen, l);
            chk("awid", out_awid, id);
            if (in_awready) aw_done = 1;
         end
         if (out_wvalid) begin
            chk("wdata", out_wdata, a + 32'(beats) * 4);
            chk("wlast", out_wlast, 64'(beats == int'(l)));
            chk("wid", out_wid, id);
            if (in_wready) begin
               beats++;
               if (out_wlast) lasts++;
            end
         end
         @(negedge aclk); cyc++;
      end
      in_awready = 1'b1; in_wready = 1'b1;
      chk("beats", beats, int'(l) + 1);
      chk("wlast_count", lasts, 1);
      chk("wvalid_after", out_wvalid, 0);
   endtask

   task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
      in_bvalid = 1'b1; in_bid = id; in_bresp = resp;
      @(negedge aclk);
      in_bvalid = 1'b0;
   endtask

   initial begin
      int cyc;
      logic [31:0] a;
      logic [3:0]  l;

      // Reset state
      #12;
      chk("rst_awvalid", out_awvalid, 0);
      chk("rst_wvalid", out_wvalid, 0);
      chk("rst_wlast", out_wlast, 0);
      chk("rst_bready", out_bready, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_ostd", ostd_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_awaddr", out_awaddr, 0);
      @(negedge aclk); aresetn = 1'b1;
      @(negedge aclk);
      chk("bready_up", out_bready, 1);
      chk("cmd_ready_up", cmd_ready, 1);

      // Single burst
      send_cmd(32'h100, 4'd3, 4'd2);
      chk("sb_awvalid", out_awvalid, 1);
      chk("sb_awsize", out_awsize, 2);
      chk("sb_awburst", out_awburst, 1);
      chk("sb_wstrb", out_wstrb, 4'hF);
      chk("sb_ostd1", ostd_cnt, 1);
      chk("sb_cmd_ready_busy", cmd_ready, 0);
      xfer(32'h100, 4'd3, 4'd2, 0, cyc);
      chk("sb_cycles", cyc, 5);
      chk("sb_cmd_ready_idle", cmd_ready, 1);
      send_b(4'd2, 2'b00);
      chk("sb_ostd0", ostd_cnt, 0);
      chk("sb_err0", err_cnt, 0);

      // Backpressure
      for (int i = 0; i < 100; i++) begin
         a = {$urandom_range(0, 32'hFFFF), 2'b00};
         l = 4'($urandom_range(0, 15));
         send_cmd(a, l, 4'(i));
         xfer(a, l, 4'(i), 1, cyc);
         send_b(4'(i), 2'b00);
      end
      chk("bp_ostd", ostd_cnt, 0);
      chk("bp_err", err_cnt, 0);

      // Outstanding limit
      for (int i = 1; i <= 4; i++) begin
         send_cmd(32'h1000 * i, 4'd0, 4'(i));
         xfer(32'h1000 * i, 4'd0, 4'(i), 0, cyc);
      end
      chk("lim_ostd4", ostd_cnt, 4);
      chk("lim_cmd_ready0", cmd_ready, 0);
      send_b(4'd1, 2'b00);
      chk("lim_ostd3", ostd_cnt, 3);
      chk("lim_cmd_ready1", cmd_ready, 1);
      send_b(4'd2, 2'b00);
      chk("sim_pre_ostd2", ostd_cnt, 2);

      // Simultaneous command and B handshake
      cmd_valid = 1'b1; cmd_addr = 32'h5000; cmd_len = 4'd0; cmd_id = 4'd5;
      in_bvalid = 1'b1; in_bid = 4'd3; in_bresp = 2'b00;
      @(negedge aclk);
      cmd_valid = 1'b0; in_bvalid = 1'b0;
      chk("sim_ostd2", ostd_cnt, 2);
      chk("sim_err0", err_cnt, 0);
      xfer(32'h5000, 4'd0, 4'd5, 0, cyc);
      send_b(4'd4, 2'b00);
      chk("sim_head4_err", err_cnt, 0);
      send_b(4'd5, 2'b00);
      chk("sim_tail5_err", err_cnt, 0);
      chk("sim_ostd0", ostd_cnt, 0);

      // Error checks
      send_cmd(32'h6000, 4'd0, 4'd6);
      xfer(32'h6000, 4'd0, 4'd6, 0, cyc);
      send_b(4'd7, 2'b00);
      chk("err_bid", err_cnt, 1);
      chk("err_bid_ostd", ostd_cnt, 0);
      send_cmd(32'h8000, 4'd0, 4'd8);
      xfer(32'h8000, 4'd0, 4'd8, 0, cyc);
      send_b(4'd8, 2'b10);
      chk("err_resp", err_cnt, 2);
      send_b(4'd0, 2'b00);
      chk("err_unexp", err_cnt, 3);
      chk("err_unexp_ostd", ostd_cnt, 0);
      in_bvalid = 1'b1; in_bid = 4'd0; in_bresp = 2'b11;
      repeat (300) @(negedge aclk);
      in_bvalid = 1'b0;
      chk("err_sat", err_cnt, 255);
      chk("err_sat_ostd", ostd_cnt, 0);

      // Reset mid-burst, during beat 2 of len=7
      send_cmd(32'h200, 4'd7, 4'd9);
      @(negedge aclk);
      @(negedge aclk);
      chk("mid_beat1", out_wdata, 32'h204);
      @(negedge aclk);
      chk("mid_beat2", out_wdata, 32'h208);
      aresetn = 1'b0;
      #1;
      chk("mid_awvalid", out_awvalid, 0);
      chk("mid_wvalid", out_wvalid, 0);
      chk("mid_wlast", out_wlast, 0);
      chk("mid_bready", out_bready, 0);
      chk("mid_cmd_ready", cmd_ready, 0);
      chk("mid_ostd", ostd_cnt, 0);
      chk("mid_err", err_cnt, 0);
      chk("mid_wdata", out_wdata, 0);
      @(negedge aclk); aresetn = 1'b1;
      @(negedge aclk);
      chk("post_cmd_ready", cmd_ready, 1);
      send_cmd(32'h300, 4'd1, 4'd3);
      xfer(32'h300, 4'd1, 4'd3, 0, cyc);
      chk("post_cycles", cyc, 3);
      send_b(4'd3, 2'b00);
      chk("post_err", err_cnt, 0);
      chk("post_ostd", ostd_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/axi_mst_wr_gen.md
# axi_mst_wr_gen

Write-traffic generator on the master side of the write path. It accepts simple burst commands and drives the AXI AW and W channels into the crossbar or slave, including the write responder model. It then consumes the B channel and checks every response against the in-order list of issued IDs. It bounds outstanding bursts and reports outstanding count and error count for the bench.

## Interface
- AXI_ADDR_W, 32: address width
- AXI_ID_W, 4: ID width
- AXI_DATA_W, 32: data width; multiple of 8
- MST_OSTDREQ_NUM, 4: maximum bursts accepted and not yet answered on B; power of 2, ≥2

Ports:
- aclk  in  1  clock; one clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  AXI_ADDR_W  burst start address
- cmd_len  in  4  beats minus 1 (0..15)
- cmd_id  in  AXI_ID_W  burst ID
- out_awvalid / in_awready  out / in  1  AW handshake
- out_awaddr, out_awlen, out_awid  out  AXI_ADDR_W, 4, AXI_ID_W  AW payload
- out_awsize  out  3  fixed $clog2(AXI_DATA_W/8)
- out_awburst  out  2  fixed 2'b01 (INCR)
- out_wvalid / in_wready  out / in  1  W handshake
- out_wdata  out  AXI_DATA_W  beat data
- out_wstrb  out  AXI_DATA_W/8  all ones
- out_wid  out  AXI_ID_W  ID of the current burst
- out_wlast  out  1  last beat
- in_bvalid / out_bready  in / out  1  B handshake
- in_bid, in_bresp  in  AXI_ID_W, 2  B payload
- ostd_cnt  out  $clog2(MST_OSTDREQ_NUM+1)  bursts accepted and not yet answered
- err_cnt  out  8  saturating response error count

## Operation
- FSM states: IDLE, AW, W.
  - IDLE → AW on command handshake. The command is latched into registers.
  - AW → W on the out_awvalid && in_awready handshake.
  - W → IDLE on a W handshake with out_wlast=1.
- cmd_ready = (state==IDLE) && (ostd_cnt < MST_OSTDREQ_NUM). This is combinational from registers.
- AW payload comes from the latched command. out_awlen = cmd_len.
- Beat counter beat_cnt is 4 bits. It is cleared on entry to W and incremented on each W handshake.
- out_wdata = latched addr + beat_cnt*(AXI_DATA_W/8), truncated to AXI_DATA_W, with LSB-aligned zero extension.
- out_wlast = (state==W) && (beat_cnt == latched len).
- ID FIFO:
  - Depth MST_OSTDREQ_NUM, with wrapping pointers of $clog2(MST_OSTDREQ_NUM) bits.
  - Push cmd_id on command handshake. Pop on B handshake when not empty.
  - The FIFO cannot overflow, because of the cmd_ready gating.
- ostd_cnt:
  - +1 on command handshake; −1 on B handshake when nonzero.
  - Both in the same cycle: unchanged.
- B check on each B handshake. err_cnt +1 (holds at 255) if any of these holds:
  - in_bresp != 2'b00;
  - in_bid != FIFO head;
  - ostd_cnt == 0 (unexpected response). In this case there is no pop and ostd_cnt stays at 0.
  - Only one increment per handshake, even if several conditions hold.
- out_bready is registered: 0 in reset, 1 from the first clock after reset release.

## Timing
- Reset values:
  - state=IDLE; out_awvalid=0, out_wvalid=0, out_wlast=0, out_bready=0.
  - All payload outputs, ostd_cnt and err_cnt = 0.
  - cmd_ready=0 while aresetn=0 (out_bready=0 masks it).
- Command handshake in cycle N → out_awvalid=1 from cycle N+1.
- AW:
  - out_awvalid and the AW payload stay stable until the handshake.
  - out_awvalid falls in the cycle after the handshake.
- W:
  - out_wvalid=1 from the cycle after the AW handshake.
  - out_wvalid stays continuously high through all beats, with no bubbles.
  - Payload stays stable while in_wready=0.
  - A burst of L+1 beats with in_wready=1 always takes exactly L+1 cycles.
- Return to idle:
  - After the wlast handshake, out_wvalid=0 and state=IDLE next cycle.
  - cmd_ready can be 1 in that cycle.
  - Minimum command spacing for a 1-beat burst with ready-high slaves is 3 cycles.
- ostd_cnt and err_cnt update in the cycle after the triggering handshake.
- B handshakes are accepted in any FSM state, including before the burst's W data completes.
- Reset asserted mid-burst: everything returns to reset values immediately. The FIFO is emptied, and no partial burst resumes.

## Test plan
- Single burst: cmd addr=0x100, len=3, id=2, with awready/wready tied high.
  - Required: AW with awaddr=0x100, awlen=3, awsize=2, awburst=1.
  - Required: wdata 0x100, 0x104, 0x108, 0x10C, with wlast on the 4th beat only.
  - B (id=2, resp=0) → ostd_cnt 1→0, err_cnt=0.
- Backpressure: random awready/wready.
  - Required: payload stable while ready is low.
  - Required: exactly len+1 W handshakes and one wlast per burst, over 100 bursts.
- Outstanding limit: issue 4 commands with B held off (in_bvalid=0).
  - Required: ostd_cnt=4 and cmd_ready=0.
  - Then one B → ostd_cnt=3 and cmd_ready=1 next cycle.
- Simultaneous events: a command handshake and a B handshake in the same cycle with ostd_cnt=2.
  - Required: ostd_cnt stays 2.
  - Required: the FIFO head advances and the new ID is queued at the tail.
- Error checks:
  - B with bid≠head → err_cnt=1.
  - bresp=2'b10 → err_cnt=2.
  - B while ostd_cnt=0 → err_cnt=3 and ostd_cnt stays 0.
  - 300 errors → err_cnt=255.
- Reset mid-burst: drop aresetn during beat 2 of len=7.
  - Required: all outputs at reset values, including out_awvalid=0 and out_wvalid=0.
  - After release, a new burst starts cleanly with beat 0.
